// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the register file array and its read sequencer.
package regfile_pkg;

  localparam int RF_DEPTH = 8;
  localparam int RF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } rseq_state_t;

endpackage

// File: rtl/regfile_addr_decoder.sv
// Address to one-hot decoder with enable; output is all-zero when disabled.
module regfile_addr_decoder #(
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_sequencer.sv
// Walks a wrapping range of register file entries and streams each word out over valid/ready.
// Optional RSEQ_PARITY_EN adds out_parity, the even parity of each captured word.
module regfile_read_sequencer
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int WIDTH = RF_WIDTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  rf_read_en,
  input  logic [WIDTH-1:0]  rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef RSEQ_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  rseq_state_t       state;
  rseq_state_t       state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   remaining_nxt;
  logic              accept;
  logic              fire;

  assign accept = out_valid && out_ready;
  // A read is issued only when the output register is free or being emptied this edge.
  assign fire   = (state == STREAM) && (remaining != '0) && (!out_valid || out_ready);
  assign remaining_nxt = fire ? (remaining - (ADDR_W+1)'(1)) : remaining;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  regfile_addr_decoder #(
    .DEPTH (DEPTH)
  ) u_decoder (
    .en     (fire),
    .addr   (cur_addr),
    .onehot (rf_read_en)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (count != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (remaining_nxt == '0) state_nxt = (remaining == '0 && accept) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (accept) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Scan pointer and remaining-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      cur_addr  <= base_addr;
      remaining <= count;
    end else if (fire) begin
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining_nxt;
    end
  end

  // Output register: loads on fire, otherwise holds until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= rf_rdata;
      out_addr  <= cur_addr;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RSEQ_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (fire) begin
      out_parity <= ^rf_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Table-driven bench for regfile_read_sequencer with a behavioural register file and a word scoreboard.
module tb_regfile_read_sequencer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] rf_read_en;
  logic [WIDTH-1:0] rf_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_addr;
`ifdef RSEQ_PARITY_EN
  logic             out_parity;
`endif

  logic [WIDTH-1:0] rf [DEPTH];

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [7:0]    rdy;
    int            exp_done;
  } vec_t;

  exp_t q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   reads    = 0;

  always #5 clk = ~clk;

  regfile_read_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rf_read_en (rf_read_en),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr)
`ifdef RSEQ_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always_comb begin
    rf_rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rf_read_en[i]) rf_rdata = rf_rdata | rf[i];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: protocol rules and scoreboard pop on every accepted word
  initial begin
    logic             prev_stall;
    logic [WIDTH-1:0] held_data;
    logic [AW-1:0]    held_addr;
    exp_t             e;
    prev_stall = 1'b0;
    held_data  = '0;
    held_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("rd_en_onehot0", int'($onehot0(rf_read_en)), 1);
        if (rf_read_en != '0) reads++;
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held_data);
          check("hold_addr", out_addr, held_addr);
        end
        if (out_valid && !out_ready) check("no_read_when_full", rf_read_en, 0);
        if (out_valid && out_ready) begin
          check("word_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("out_data", out_data, e.data);
            check("out_addr", out_addr, e.addr);
`ifdef RSEQ_PARITY_EN
            check("out_parity", out_parity, ^e.data);
`endif
          end
        end
        prev_stall = out_valid && !out_ready;
        held_data  = out_data;
        held_addr  = out_addr;
      end
    end
  end

  // One scan; out_ready in cycle c (c=0 is the start cycle) is rdy[c%8].
  // start is held high with junk operands while busy to show it is ignored.
  task automatic run_scan(input logic [AW-1:0] b, input logic [AW:0] n,
                          input logic [7:0] rdy, input int exp_done);
    int   done_cyc;
    int   rd0;
    exp_t e;
    @(posedge clk); #1;
    base_addr = b;
    count     = n;
    start     = 1'b1;
    out_ready = rdy[0];
    for (int i = 0; i < int'(n); i++) begin
      e.addr = b + AW'(i);
      e.data = rf[e.addr];
      q.push_back(e);
    end
    rd0      = reads;
    done_cyc = -1;
    for (int c = 1; c < 100; c++) begin
      @(posedge clk); #1;
      base_addr = AW'($urandom);
      count     = (AW+1)'($urandom_range(1, DEPTH));
      out_ready = rdy[c % 8];
      @(negedge clk);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("done_cycle", done_cyc, exp_done);
    if (done_cyc > 0) check("busy_in_done", busy, 1);
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("read_count", reads - rd0, int'(n));
    check("scoreboard_empty", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rf[i] = 8'hA0 + 8'(i);
    // {base, count, ready pattern (bit c = cycle c), done cycle after start edge}
    vecs[0] = '{3'd0, 4'd8, 8'hFF,        10};
    vecs[1] = '{3'd6, 4'd4, 8'hFF,         6};
    vecs[2] = '{3'd2, 4'd3, 8'b1110_1001,  7};
    vecs[3] = '{3'd3, 4'd0, 8'hFF,         1};
    vecs[4] = '{3'd7, 4'd1, 8'hFF,         3};
    vecs[5] = '{3'd5, 4'd8, 8'hFF,        10};
    vecs[6] = '{3'd1, 4'd2, 8'b1010_1010,  6};

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    count     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", rf_read_en, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++)
      run_scan(vecs[v].base, vecs[v].cnt, vecs[v].rdy, vecs[v].exp_done);

    // Reset two cycles into a full scan aborts it and drops the held word
    @(posedge clk); #1;
    base_addr = 3'd0;
    count     = 4'd8;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_en", rf_read_en, 0);
    q.delete();
    run_scan(3'd3, 4'd1, 8'hFF, 3);

`ifdef RSEQ_PARITY_EN
    rf[5] = 8'h07;
    run_scan(3'd5, 4'd1, 8'hFF, 3);
    rf[5] = 8'h03;
    run_scan(3'd5, 4'd1, 8'hFF, 3);
    rf[5] = 8'hA5;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
